// File: rtl/cam_color_stats.sv
// Per-frame colour classifier snooping the RGB444 capture write stream.
// Counts red/green/blue-dominant pixels over one frame, then publishes the
// three counts and the dominant colour code as a one-cycle result pulse.
module cam_color_stats #(
   parameter int AW       = 15,
   parameter int DW       = 12,
   parameter int IMG_SIZE = 19200,
   parameter int TH       = 3,
   parameter int MIN_PIX  = 200,
   parameter int CW       = 15
) (
   input  logic          CAM_pclk,
   input  logic          rst,
   input  logic          CAM_vsync,
   input  logic          px_we,
   input  logic [AW-1:0] px_addr,
   input  logic [DW-1:0] px_data,
   output logic          result_valid,
   output logic [1:0]    color_code,
   output logic [CW-1:0] cnt_red,
   output logic [CW-1:0] cnt_green,
   output logic [CW-1:0] cnt_blue,
   output logic          frame_err
);

   typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_DECIDE} state_t;

   localparam logic [AW-1:0] LAST_ADDR = AW'(IMG_SIZE - 1);
   localparam logic [4:0]    TH5       = 5'(TH);
   localparam logic [CW-1:0] MIN_CNT   = CW'(MIN_PIX);

   // Saturating increment: a full counter stays at all-ones.
   function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v, input logic en);
      if (en && (v != {CW{1'b1}}))
         return v + CW'(1);
      return v;
   endfunction

   state_t        state_q, state_d;
   logic [CW-1:0] acc_r_q, acc_r_d, acc_g_q, acc_g_d, acc_b_q, acc_b_d;
   logic [AW-1:0] exp_addr_q, exp_addr_d;
   logic [CW-1:0] cnt_r_q, cnt_r_d, cnt_g_q, cnt_g_d, cnt_b_q, cnt_b_d;
   logic [1:0]    color_q, color_d;
   logic          result_valid_q, result_valid_d;
   logic          frame_err_q, frame_err_d;

   logic [4:0]    r5, g5, b5;
   logic          is_red, is_green, is_blue;
   logic [1:0]    win_code;
   logic [CW-1:0] win_cnt;

   // Classify the incoming pixel with 5-bit compares so C+TH cannot wrap.
   always_comb begin
      r5       = {1'b0, px_data[11:8]};
      g5       = {1'b0, px_data[7:4]};
      b5       = {1'b0, px_data[3:0]};
      is_red   = (r5 > g5 + TH5) && (r5 > b5 + TH5);
      is_green = (g5 > r5 + TH5) && (g5 > b5 + TH5);
      is_blue  = (b5 > r5 + TH5) && (b5 > g5 + TH5);
   end

   // Pick the largest accumulated count; ties favour red, then green.
   always_comb begin
      win_code = 2'd1;
      win_cnt  = acc_r_q;
      if ((acc_g_q > acc_r_q) && (acc_g_q >= acc_b_q)) begin
         win_code = 2'd2;
         win_cnt  = acc_g_q;
      end else if ((acc_b_q > acc_r_q) && (acc_b_q > acc_g_q)) begin
         win_code = 2'd3;
         win_cnt  = acc_b_q;
      end
   end

   // Frame tracking FSM: next state, accumulators and published result.
   always_comb begin
      state_d        = state_q;
      acc_r_d        = acc_r_q;
      acc_g_d        = acc_g_q;
      acc_b_d        = acc_b_q;
      exp_addr_d     = exp_addr_q;
      cnt_r_d        = cnt_r_q;
      cnt_g_d        = cnt_g_q;
      cnt_b_d        = cnt_b_q;
      color_d        = color_q;
      result_valid_d = 1'b0;
      frame_err_d    = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (px_we && (px_addr == '0) && !CAM_vsync) begin
               acc_r_d    = CW'(is_red);
               acc_g_d    = CW'(is_green);
               acc_b_d    = CW'(is_blue);
               exp_addr_d = AW'(1);
               state_d    = S_ACCUM;
            end
         end
         S_ACCUM: begin
            if (CAM_vsync) begin
               frame_err_d = 1'b1;
               state_d     = S_IDLE;
            end else if (px_we) begin
               if (px_addr != exp_addr_q) begin
                  frame_err_d = 1'b1;
                  state_d     = S_IDLE;
               end else begin
                  acc_r_d    = sat_inc(acc_r_q, is_red);
                  acc_g_d    = sat_inc(acc_g_q, is_green);
                  acc_b_d    = sat_inc(acc_b_q, is_blue);
                  exp_addr_d = exp_addr_q + AW'(1);
                  if (px_addr == LAST_ADDR)
                     state_d = S_DECIDE;
               end
            end
         end
         S_DECIDE: begin
            cnt_r_d        = acc_r_q;
            cnt_g_d        = acc_g_q;
            cnt_b_d        = acc_b_q;
            color_d        = (win_cnt >= MIN_CNT) ? win_code : 2'd0;
            result_valid_d = 1'b1;
            state_d        = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State, accumulator and output registers; reset clears everything.
   always_ff @(posedge CAM_pclk) begin
      if (rst) begin
         state_q        <= S_IDLE;
         acc_r_q        <= '0;
         acc_g_q        <= '0;
         acc_b_q        <= '0;
         exp_addr_q     <= '0;
         cnt_r_q        <= '0;
         cnt_g_q        <= '0;
         cnt_b_q        <= '0;
         color_q        <= '0;
         result_valid_q <= 1'b0;
         frame_err_q    <= 1'b0;
      end else begin
         state_q        <= state_d;
         acc_r_q        <= acc_r_d;
         acc_g_q        <= acc_g_d;
         acc_b_q        <= acc_b_d;
         exp_addr_q     <= exp_addr_d;
         cnt_r_q        <= cnt_r_d;
         cnt_g_q        <= cnt_g_d;
         cnt_b_q        <= cnt_b_d;
         color_q        <= color_d;
         result_valid_q <= result_valid_d;
         frame_err_q    <= frame_err_d;
      end
   end

   assign result_valid = result_valid_q;
   assign frame_err    = frame_err_q;
   assign color_code   = color_q;
   assign cnt_red      = cnt_r_q;
   assign cnt_green    = cnt_g_q;
   assign cnt_blue     = cnt_b_q;

endmodule

// File: tb/tb_cam_color_stats.sv
// Scoreboard bench for cam_color_stats: stimulus pushes the expected pulse
// (kind, cycle, colour, counts); a negedge monitor pops and compares.
module tb_cam_color_stats;

   localparam int IMG = 19200;

   logic        clk = 1'b0;
   logic        rst;
   logic        vsync;
   logic        px_we;
   logic [14:0] px_addr;
   logic [11:0] px_data;
   logic        result_valid;
   logic [1:0]  color_code;
   logic [14:0] cnt_red, cnt_green, cnt_blue;
   logic        frame_err;

   typedef struct {
      bit is_err;
      int cyc;
      int col;
      int r;
      int g;
      int b;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   int   cyc = 0;
   int   last_k;
   int   pass_cnt = 0;
   int   total_cnt = 0;
   int   pub_col = 0, pub_r = 0, pub_g = 0, pub_b = 0;

   cam_color_stats dut (
      .CAM_pclk     (clk),
      .rst          (rst),
      .CAM_vsync    (vsync),
      .px_we        (px_we),
      .px_addr      (px_addr),
      .px_data      (px_data),
      .result_valid (result_valid),
      .color_code   (color_code),
      .cnt_red      (cnt_red),
      .cnt_green    (cnt_green),
      .cnt_blue     (cnt_blue),
      .frame_err    (frame_err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input int act, input int exp);
      total_cnt++;
      if (act == exp) pass_cnt++;
      else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
   endtask

   function automatic logic [11:0] pix(input int mode, input int a);
      case (mode)
         0: return 12'hF00;
         1: begin
            if (a < 100) return 12'h0F0;
            if (a < 200) return 12'h00F;
            if (a == 200) return 12'h520;
            return 12'h888;
         end
         default: begin
            if (a < 300) return 12'h0F0;
            if (a < 600) return 12'h00F;
            if (a == 600) return 12'h620;
            return 12'h888;
         end
      endcase
   endfunction

   task automatic wr(input int a, input logic [11:0] d);
      @(negedge clk);
      px_we   = 1'b1;
      px_addr = 15'(a);
      px_data = d;
      last_k  = cyc;
   endtask

   task automatic idle_cyc(input int n);
      repeat (n) begin
         @(negedge clk);
         px_we = 1'b0;
      end
   endtask

   task automatic push(input bit is_err, input int c, input int col, input int r, input int g, input int b);
      exp_t e;
      e.is_err = is_err;
      e.cyc    = c;
      e.col    = col;
      e.r      = r;
      e.g      = g;
      e.b      = b;
      sb.push_back(e);
   endtask

   task automatic run_frame(input int mode, input bit gap, input int col, input int r, input int g, input int b);
      for (int a = 0; a < IMG; a++) begin
         wr(a, pix(mode, a));
         if (gap) idle_cyc(1);
      end
      push(1'b0, last_k + 2, col, r, g, b);
      pub_col = col; pub_r = r; pub_g = g; pub_b = b;
      idle_cyc(4);
   endtask

   task automatic chk_outputs(input string tag, input int col, input int r, input int g, input int b);
      chk({tag, "_color"}, color_code, col);
      chk({tag, "_red"}, cnt_red, r);
      chk({tag, "_green"}, cnt_green, g);
      chk({tag, "_blue"}, cnt_blue, b);
      chk({tag, "_rv"}, result_valid, 0);
      chk({tag, "_fe"}, frame_err, 0);
   endtask

   // Monitor: every asserted pulse cycle must match the next scoreboard entry.
   initial begin
      forever begin
         @(negedge clk);
         if (result_valid && frame_err) chk("rv_fe_exclusive", 1, 0);
         if (result_valid || frame_err) begin
            if (sb.size() == 0) begin
               chk("unexpected_pulse", {30'd0, frame_err, result_valid}, 0);
            end else begin
               mon_e = sb.pop_front();
               chk("pulse_kind_err", frame_err, int'(mon_e.is_err));
               chk("pulse_cycle", cyc, mon_e.cyc);
               chk("pulse_color", color_code, mon_e.col);
               chk("pulse_red", cnt_red, mon_e.r);
               chk("pulse_green", cnt_green, mon_e.g);
               chk("pulse_blue", cnt_blue, mon_e.b);
            end
         end
      end
   end

   initial begin
      rst = 1'b1; vsync = 1'b0; px_we = 1'b0; px_addr = '0; px_data = '0;
      repeat (3) @(negedge clk);
      chk_outputs("reset", 0, 0, 0, 0);
      rst = 1'b0;
      idle_cyc(2);

      // Full red frame, writes every second pclk.
      run_frame(0, 1'b1, 1, IMG, 0, 0);
      chk_outputs("red_hold", 1, IMG, 0, 0);

      // vsync abort after addr 5000; vsync wins over a same-cycle write.
      for (int a = 0; a <= 5000; a++) wr(a, 12'h0F0);
      @(negedge clk);
      px_we = 1'b1; px_addr = 15'd5001; px_data = 12'h0F0; vsync = 1'b1;
      push(1'b1, cyc + 1, pub_col, pub_r, pub_g, pub_b);
      idle_cyc(3);
      vsync = 1'b0;
      idle_cyc(2);
      chk_outputs("abort_hold", 1, IMG, 0, 0);

      // Address skip 0,1,2,4 -> error; later non-zero writes are ignored.
      wr(0, 12'h888); wr(1, 12'h888); wr(2, 12'h888);
      wr(4, 12'h888);
      push(1'b1, last_k + 1, pub_col, pub_r, pub_g, pub_b);
      idle_cyc(1);
      wr(3, 12'hF00); wr(5, 12'hF00);
      idle_cyc(3);

      // Green/blue tie below the minimum; addr 200 is 12'h520 (not red).
      run_frame(1, 1'b0, 0, 0, 100, 100);

      // Reset mid-frame clears outputs without a pulse.
      for (int a = 0; a <= 9000; a++) wr(a, 12'hF00);
      @(negedge clk);
      px_we = 1'b0; rst = 1'b1;
      @(negedge clk);
      chk_outputs("midrst", 0, 0, 0, 0);
      rst = 1'b0;
      pub_col = 0; pub_r = 0; pub_g = 0; pub_b = 0;
      idle_cyc(2);

      // Green/blue tie above the minimum; addr 600 is 12'h620 (red).
      run_frame(2, 1'b0, 2, 1, 300, 300);
      chk_outputs("final_hold", 2, 1, 300, 300);

      idle_cyc(6);
      chk("scoreboard_empty", sb.size(), 0);
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
